sample_stream_fifo: RTL and testbench

Parametrised successor to the single-register stream test design. Buffers a valid/ready byte stream through a DEPTH-entry first-word-fall-through FIFO. Exposes fill level, a sticky high-watermark and wrapping transfer counters so simulator-interface tests can probe handshakes, memories and counters. Sits as a standalone top-level test design.

---
 rtl/sample_stream_pkg.sv | 18 +
 rtl/sample_stream_counter.sv | 19 +
 rtl/sample_stream_fifo.sv | 99 +++++++++
 tb/tb_sample_stream_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_stream_pkg.sv
// Shared types and helpers for the sample stream FIFO test design.
package sample_stream_pkg;

    localparam int COUNT_W_DEFAULT = 16;

    typedef logic [COUNT_W_DEFAULT-1:0] count_t;

    // Handshake pair bundled for probing one side of a valid/ready link.
    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sample_stream_counter.sv
// Wrapping event counter with synchronous clear and count enable.
module sample_stream_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sample_stream_fifo.sv
// First-word-fall-through byte-stream FIFO with occupancy, high-watermark and transfer counters.
// Handshake: a word moves on a rising edge where valid and ready are both high; ready never depends on the consumer side.
module sample_stream_fifo
    import sample_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = COUNT_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stream_in_valid,
    output logic                        stream_in_ready,
    input  logic [DATA_WIDTH-1:0]       stream_in_data,
    output logic                        stream_out_valid,
    input  logic                        stream_out_ready,
    output logic [DATA_WIDTH-1:0]       stream_out_data,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic [level_w(DEPTH)-1:0]   high_watermark,
    output logic [COUNT_WIDTH-1:0]      in_count,
    output logic [COUNT_WIDTH-1:0]      out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LW    = level_w(DEPTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sample_stream_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LW-1:0]         level_q;
    logic [LW-1:0]         level_next;
    logic [LW-1:0]         hwm_q;
    hs_t                   in_hs;
    hs_t                   out_hs;
    logic                  push;
    logic                  pop;

    assign stream_in_ready  = (level_q != FULL_LEVEL);
    assign stream_out_valid = (level_q != '0);
    assign stream_out_data  = storage[rd_ptr];

    assign in_hs  = '{valid: stream_in_valid, ready: stream_in_ready};
    assign out_hs = '{valid: stream_out_valid, ready: stream_out_ready};
    assign push   = in_hs.valid & in_hs.ready;
    assign pop    = out_hs.valid & out_hs.ready;

    always_comb begin
        level_next = level_q;
        case ({push, pop})
            2'b10:   level_next = level_q + LW'(1);
            2'b01:   level_next = level_q - LW'(1);
            default: level_next = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            hwm_q   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level_q <= level_next;
            if (level_next > hwm_q) hwm_q <= level_next;
        end
    end

    // Storage is deliberately left uncleared; only the pointers define content.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            storage[wr_ptr] <= stream_in_data;
        end
    end

    sample_stream_counter #(.WIDTH(COUNT_WIDTH)) u_in_counter (
        .clk    (clk),
        .clear  (rst),
        .enable (push),
        .count  (in_count)
    );

    sample_stream_counter #(.WIDTH(COUNT_WIDTH)) u_out_counter (
        .clk    (clk),
        .clear  (rst),
        .enable (pop),
        .count  (out_count)
    );

    assign level          = level_q;
    assign high_watermark = hwm_q;

endmodule

// File: tb/tb_sample_stream_fifo.sv
// Scoreboard bench for sample_stream_fifo (DEPTH=4, 4-bit counters to exercise wrap).
module tb_sample_stream_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int LW    = 3;
    localparam int CMOD  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          stream_in_valid;
    logic          stream_in_ready;
    logic [DW-1:0] stream_in_data;
    logic          stream_out_valid;
    logic          stream_out_ready;
    logic [DW-1:0] stream_out_data;
    logic [LW-1:0] level;
    logic [LW-1:0] high_watermark;
    logic [CW-1:0] in_count;
    logic [CW-1:0] out_count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    int m_level, m_hwm, m_in, m_out;

    sample_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .stream_in_valid  (stream_in_valid),
        .stream_in_ready  (stream_in_ready),
        .stream_in_data   (stream_in_data),
        .stream_out_valid (stream_out_valid),
        .stream_out_ready (stream_out_ready),
        .stream_out_data  (stream_out_data),
        .level            (level),
        .high_watermark   (high_watermark),
        .in_count         (in_count),
        .out_count        (out_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset(input int n);
        rst              = 1'b1;
        stream_in_valid  = 1'b0;
        stream_in_data   = '0;
        stream_out_ready = 1'b0;
        repeat (n) @(posedge clk);
        m_level = 0;
        m_hwm   = 0;
        m_in    = 0;
        m_out   = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; drives one cycle, updates the model, returns at the next falling edge.
    task automatic drive_cycle(input logic iv, input logic [DW-1:0] id, input logic ordy,
                               output logic did_push, output logic did_pop,
                               output logic [DW-1:0] pop_data);
        stream_in_valid  = iv;
        stream_in_data   = id;
        stream_out_ready = ordy;
        did_push = iv && (m_level != DEPTH);
        did_pop  = ordy && (m_level != 0);
        pop_data = stream_out_data;
        if (did_push) exp_q.push_back(id);
        @(posedge clk);
        m_level = m_level + int'(did_push) - int'(did_pop);
        if (m_level > m_hwm) m_hwm = m_level;
        m_in  = (m_in + int'(did_push)) % CMOD;
        m_out = (m_out + int'(did_pop)) % CMOD;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset(2);
        checks++; if (stream_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", stream_in_ready); end
        checks++; if (stream_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", stream_out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (high_watermark !== 3'd0) begin failures++; $display("FAIL reset_hwm got=%0d exp=0", high_watermark); end
        checks++; if (in_count !== 4'd0 || out_count !== 4'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", in_count, out_count); end
    endtask

    task automatic test_single_word();
        logic p, q;
        logic [DW-1:0] d, e;
        apply_reset(1);
        drive_cycle(1'b1, 8'hA5, 1'b0, p, q, d);
        checks++; if (stream_out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", stream_out_valid); end
        checks++; if (stream_out_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", stream_out_data); end
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
        drive_cycle(1'b0, 8'h00, 1'b1, p, q, d);
        if (q) begin
            e = exp_q.pop_front();
            checks++; if (d !== e) begin failures++; $display("FAIL single_pop got=%h exp=%h", d, e); end
        end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL single_level_after got=%0d exp=0", level); end
        checks++; if (out_count !== 4'd1) begin failures++; $display("FAIL single_out_count got=%0d exp=1", out_count); end
        checks++; if (stream_out_valid !== 1'b0) begin failures++; $display("FAIL single_empty_valid got=%b exp=0", stream_out_valid); end
    endtask

    task automatic test_fill_wrap();
        logic p, q;
        logic [DW-1:0] d, e;
        apply_reset(1);
        for (int i = 1; i <= 4; i++) drive_cycle(1'b1, DW'(i), 1'b0, p, q, d);
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL fill_level got=%0d exp=4", level); end
        checks++; if (stream_in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", stream_in_ready); end
        checks++; if (high_watermark !== 3'd4) begin failures++; $display("FAIL fill_hwm got=%0d exp=4", high_watermark); end
        // Full with a pop: 0x05 must wait one cycle.
        drive_cycle(1'b1, 8'h05, 1'b1, p, q, d);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL full_pop_first got=%h exp=01", d); end
        if (q) void'(exp_q.pop_front());
        checks++; if (in_count !== 4'd4 || level !== 3'd3) begin failures++; $display("FAIL full_no_push got=in%0d/lvl%0d exp=in4/lvl3", in_count, level); end
        drive_cycle(1'b1, 8'h05, 1'b0, p, q, d);
        checks++; if (in_count !== 4'd5 || level !== 3'd4) begin failures++; $display("FAIL full_late_push got=in%0d/lvl%0d exp=in5/lvl4", in_count, level); end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, p, q, d);
            if (q) begin
                e = exp_q.pop_front();
                checks++; if (d !== e || d !== DW'(i + 2)) begin failures++; $display("FAIL drain_%0d got=%h exp=%h", i, d, DW'(i + 2)); end
            end
        end
        checks++; if (level !== 3'd0 || exp_q.size() != 0) begin failures++; $display("FAIL drain_empty got=lvl%0d/q%0d exp=0/0", level, exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic p, q;
        logic [DW-1:0] d, e;
        logic [CW-1:0] diff;
        apply_reset(1);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, DW'(8'h40 + i), 1'b1, p, q, d);
            if (q) begin
                e = exp_q.pop_front();
                checks++; if (d !== e || d !== DW'(8'h40 + i - 1)) begin failures++; $display("FAIL stream_data_%0d got=%h exp=%h", i, d, e); end
            end
            checks++; if (level !== 3'd1) begin failures++; $display("FAIL stream_level_%0d got=%0d exp=1", i, level); end
            diff = in_count - out_count;
            checks++; if (diff !== CW'(level)) begin failures++; $display("FAIL stream_invariant_%0d got=%0d exp=%0d", i, diff, level); end
        end
        checks++; if (high_watermark !== 3'd1) begin failures++; $display("FAIL stream_hwm got=%0d exp=1", high_watermark); end
    endtask

    task automatic test_counter_wrap();
        logic p, q;
        logic [DW-1:0] d, e;
        apply_reset(1);
        for (int i = 0; i < 17; i++) begin
            drive_cycle(1'b1, DW'(i), 1'b1, p, q, d);
            if (q) begin
                e = exp_q.pop_front();
                checks++; if (d !== e) begin failures++; $display("FAIL wrap_data_%0d got=%h exp=%h", i, d, e); end
            end
        end
        drive_cycle(1'b0, 8'h00, 1'b1, p, q, d);
        if (q) begin
            e = exp_q.pop_front();
            checks++; if (d !== e) begin failures++; $display("FAIL wrap_last got=%h exp=%h", d, e); end
        end
        checks++; if (in_count !== 4'd1) begin failures++; $display("FAIL wrap_in_count got=%0d exp=1", in_count); end
        checks++; if (out_count !== 4'd1) begin failures++; $display("FAIL wrap_out_count got=%0d exp=1", out_count); end
    endtask

    task automatic test_reset_mid();
        logic p, q;
        logic [DW-1:0] d, e;
        apply_reset(1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, DW'(8'h70 + i), 1'b0, p, q, d);
        checks++; if (level !== 3'd3 || high_watermark !== 3'd3) begin failures++; $display("FAIL mid_pre got=lvl%0d/hwm%0d exp=3/3", level, high_watermark); end
        // Reset lands together with a push and a pop; reset must win.
        rst = 1'b1; stream_in_valid = 1'b1; stream_in_data = 8'hEE; stream_out_ready = 1'b1;
        @(posedge clk);
        m_level = 0; m_hwm = 0; m_in = 0; m_out = 0; exp_q.delete();
        @(negedge clk);
        rst = 1'b0; stream_in_valid = 1'b0; stream_out_ready = 1'b0;
        checks++; if (level !== 3'd0 || stream_out_valid !== 1'b0 || stream_in_ready !== 1'b1) begin failures++; $display("FAIL mid_after got=lvl%0d/v%b/r%b exp=0/0/1", level, stream_out_valid, stream_in_ready); end
        checks++; if (high_watermark !== 3'd0 || in_count !== 4'd0 || out_count !== 4'd0) begin failures++; $display("FAIL mid_clear got=hwm%0d/in%0d/out%0d exp=0/0/0", high_watermark, in_count, out_count); end
        drive_cycle(1'b1, 8'h5A, 1'b0, p, q, d);
        drive_cycle(1'b0, 8'h00, 1'b1, p, q, d);
        if (q) begin
            e = exp_q.pop_front();
            checks++; if (d !== e || d !== 8'h5A) begin failures++; $display("FAIL mid_first_out got=%h exp=5a", d); end
        end
    endtask

    task automatic test_random();
        logic p, q, iv, ordy;
        logic [DW-1:0] d, e, id;
        logic [CW-1:0] diff;
        apply_reset(1);
        iv = 1'b0; id = '0; p = 1'b0;
        for (int i = 0; i < 300; i++) begin
            // A raised valid stays raised with the same data until accepted.
            if (!(iv && !p)) begin
                iv = 1'($urandom_range(0, 1));
                id = DW'($urandom_range(0, 255));
            end
            ordy = ($urandom_range(0, 3) != 0) ^ (i >= 150);
            drive_cycle(iv, id, ordy, p, q, d);
            if (q) begin
                e = exp_q.pop_front();
                checks++; if (d !== e) begin failures++; $display("FAIL rand_data_%0d got=%h exp=%h", i, d, e); end
            end
            checks++; if (level !== LW'(m_level)) begin failures++; $display("FAIL rand_level_%0d got=%0d exp=%0d", i, level, m_level); end
            diff = in_count - out_count;
            checks++; if (diff !== CW'(level)) begin failures++; $display("FAIL rand_invariant_%0d got=%0d exp=%0d", i, diff, level); end
        end
        checks++; if (high_watermark !== LW'(m_hwm)) begin failures++; $display("FAIL rand_hwm got=%0d exp=%0d", high_watermark, m_hwm); end
        checks++; if (in_count !== CW'(m_in) || out_count !== CW'(m_out)) begin failures++; $display("FAIL rand_counts got=%0d/%0d exp=%0d/%0d", in_count, out_count, m_in, m_out); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst              = 1'b1;
        stream_in_valid  = 1'b0;
        stream_in_data   = '0;
        stream_out_ready = 1'b0;
        test_reset();
        test_single_word();
        test_fill_wrap();
        test_back_to_back();
        test_counter_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
